// File: rtl/simd_top.sv
// simd_top: single-issue vector engine over a shared word-addressed memory.
// It pops one command at a time from an external FIFO and streams the
// command's elements through the engine at one element per cycle.
//   i_clk           : clock, rising edge
//   i_rstn          : synchronous reset, active high
//   queue_cmd       : head of the external command FIFO (cmd_t)
//   queue_empty     : external FIFO holds no command
//   issuer_rd_queue : one-cycle pop strobe to the FIFO
//   finished_task   : issuer idle and FIFO empty

package simd_pkg;
  typedef struct packed {
    logic [1:0]  opcode;
    logic [7:0]  len;
    logic [17:0] addr_a;
    logic [17:0] addr_b;
    logic [17:0] addr_d;
  } cmd_t;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_DOT  = 2'd2;
  localparam logic [1:0] OP_COPY = 2'd3;
endpackage

// simd_mem: storage array, one write port and two registered read ports.
//   clk_i, we_i, waddr_i, wdata_i : write port
//   raddr_a_i/raddr_b_i -> rdata_a_o/rdata_b_o : data one cycle later
//   A read and a write to the same word on one edge return the old word.
module simd_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
    rdata_a_o <= r_mem[raddr_a_i];
    rdata_b_o <= r_mem[raddr_b_i];
  end
endmodule

// simd_shared_mem: wrapper giving the storage its fixed hierarchical name.
//   Ports as simd_mem.
module simd_shared_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);
  simd_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk_i     (clk_i),
    .we_i      (we_i),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .raddr_a_i (raddr_a_i),
    .raddr_b_i (raddr_b_i),
    .rdata_a_o (rdata_a_o),
    .rdata_b_o (rdata_b_o)
  );
endmodule

// simd_pool: execution engine. Takes the element read issued last cycle,
// combines the returned operands and produces the memory write.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   el_valid_i/idx_i/last_i: element read issued this cycle, its index, final flag
//   op_i, addr_d_i         : opcode and destination base of the active command
//   rdata_a_i, rdata_b_i   : operands of the element read last cycle
//   we_o, waddr_o, wdata_o : memory write port
module simd_pool #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              el_valid_i,
  input  logic [8:0]        el_idx_i,
  input  logic              el_last_i,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] addr_d_i,
  input  logic [DATA_W-1:0] rdata_a_i,
  input  logic [DATA_W-1:0] rdata_b_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
);
  import simd_pkg::*;

  logic              valid_q;
  logic              last_q;
  logic [8:0]        idx_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] prod;

  assign prod = rdata_a_i * rdata_b_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      valid_q <= el_valid_i;
      last_q  <= el_last_i;
      idx_q   <= el_idx_i;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    wdata_o = rdata_a_i;
    case (op_i)
      OP_ADD:  wdata_o = rdata_a_i + rdata_b_i;
      OP_SUB:  wdata_o = rdata_a_i - rdata_b_i;
      OP_DOT:  wdata_o = acc_q + prod;
      OP_COPY: wdata_o = rdata_a_i;
      default: wdata_o = rdata_a_i;
    endcase
    // Accumulator self-clears after the final DOT element so the next command starts at zero.
    if (valid_q) acc_d = last_q ? '0 : acc_q + prod;
    we_o    = valid_q && !rst_i && ((op_i != OP_DOT) || last_q);
    waddr_o = addr_d_i + ((op_i == OP_DOT) ? '0 : ADDR_W'(idx_q));
  end
endmodule

module simd_top #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  simd_pkg::cmd_t queue_cmd,
  input  logic           queue_empty,
  output logic           issuer_rd_queue,
  output logic           finished_task
);
  import simd_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [8:0]  idx_q, idx_d;
  logic [8:0]  len_eff;
  logic        el_valid, el_last;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr, raddr_a, raddr_b;
  logic [DATA_W-1:0] mem_wdata, rdata_a, rdata_b;

  assign len_eff = (cmd_q.len == 8'd0) ? 9'd256 : {1'b0, cmd_q.len};
  assign el_last = (idx_q == len_eff - 9'd1);
  assign raddr_a = ADDR_W'(cmd_q.addr_a) + ADDR_W'(idx_q);
  assign raddr_b = ADDR_W'(cmd_q.addr_b) + ADDR_W'(idx_q);

  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    idx_d           = idx_q;
    issuer_rd_queue = 1'b0;
    el_valid        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!queue_empty && !i_rstn) begin
          issuer_rd_queue = 1'b1;
          cmd_d           = queue_cmd;
          idx_d           = '0;
          state_d         = S_EXEC;
        end
      end
      S_EXEC: begin
        el_valid = 1'b1;
        if (el_last) state_d = S_WB;
        else         idx_d   = idx_q + 9'd1;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign finished_task = (state_q == S_IDLE) && queue_empty;

  simd_shared_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_shared_mem (
    .clk_i     (i_clk),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .raddr_a_i (raddr_a),
    .raddr_b_i (raddr_b),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

  simd_pool #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pool (
    .clk_i      (i_clk),
    .rst_i      (i_rstn),
    .el_valid_i (el_valid),
    .el_idx_i   (idx_q),
    .el_last_i  (el_last),
    .op_i       (cmd_q.opcode),
    .addr_d_i   (ADDR_W'(cmd_q.addr_d)),
    .rdata_a_i  (rdata_a),
    .rdata_b_i  (rdata_b),
    .we_o       (mem_we),
    .waddr_o    (mem_waddr),
    .wdata_o    (mem_wdata)
  );
endmodule

// File: tb/tb_simd_top.sv
module tb_simd_top;
  localparam int unsigned DEPTH = 262144;
  localparam int unsigned TOPW  = DEPTH - 16;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b1;
  logic [63:0] queue_cmd = '0;
  logic        queue_empty = 1'b1;
  logic        issuer_rd_queue;
  logic        finished_task;

  logic [31:0] ref_mem [DEPTH];
  logic [63:0] pending [$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned dut_pops = 0;

  simd_top #(.DATA_W(32), .ADDR_W(18)) dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .queue_cmd       (queue_cmd),
    .queue_empty     (queue_empty),
    .issuer_rd_queue (issuer_rd_queue),
    .finished_task   (finished_task)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int unsigned op, input int unsigned len,
                                     input int unsigned a, input int unsigned b,
                                     input int unsigned d);
    logic [63:0] c;
    c = {op[1:0], len[7:0], a[17:0], b[17:0], d[17:0]};
    return c;
  endfunction

  function automatic int unsigned len_eff(input logic [63:0] c);
    return (c[61:54] == 8'd0) ? 256 : 32'(c[61:54]);
  endfunction

  task automatic poke(input logic [17:0] addr, input logic [31:0] val);
    dut.u_shared_mem.u_mem.r_mem[addr] = val;
    ref_mem[addr] = val;
  endtask

  function automatic logic [31:0] peek(input logic [17:0] addr);
    return dut.u_shared_mem.u_mem.r_mem[addr];
  endfunction

  // Reference semantics: elements in ascending order; element i+1 is read
  // before element i is written. Only the first nwr elements get written.
  function automatic void model_exec(input logic [63:0] c, input int unsigned nwr);
    int unsigned op, n, a, b, d, j;
    logic [31:0] va [256];
    logic [31:0] vb [256];
    logic [31:0] acc;
    op  = 32'(c[63:62]);
    n   = len_eff(c);
    a   = 32'(c[53:36]);
    b   = 32'(c[35:18]);
    d   = 32'(c[17:0]);
    acc = '0;
    for (int unsigned i = 0; i <= n; i++) begin
      if (i < n) begin
        va[i] = ref_mem[18'(a + i)];
        vb[i] = ref_mem[18'(b + i)];
      end
      if (i > 0 && i <= nwr) begin
        j = i - 1;
        case (op)
          0: ref_mem[18'(d + j)] = va[j] + vb[j];
          1: ref_mem[18'(d + j)] = va[j] - vb[j];
          2: begin
            acc = acc + va[j] * vb[j];
            if (j == n - 1) ref_mem[18'(d)] = acc;
          end
          default: ref_mem[18'(d + j)] = va[j];
        endcase
      end
    end
  endfunction

  task automatic compare_window();
    for (int unsigned i = 0; i < 1024; i++)
      check_eq($sformatf("mem[%0h]", i), peek(18'(i)), ref_mem[18'(i)]);
    for (int unsigned i = TOPW; i < DEPTH; i++)
      check_eq($sformatf("mem[%0h]", i), peek(18'(i)), ref_mem[18'(i)]);
  endtask

  // Feeds everything in 'pending' as a FIFO and checks pop/finished timing
  // every cycle: a command popped on cycle t occupies the issuer until t+len_eff+2.
  task automatic run_stream();
    int unsigned t, busy_until;
    logic        idle;
    logic [63:0] c;
    t = 0;
    busy_until = 0;
    @(negedge i_clk);
    forever begin
      queue_empty = (pending.size() == 0);
      queue_cmd   = queue_empty ? {$urandom, $urandom} : pending[0];
      #1;
      idle = (t >= busy_until);
      if (issuer_rd_queue) dut_pops++;
      check_eq("finished_task", finished_task, idle && queue_empty);
      check_eq("issuer_rd_queue", issuer_rd_queue, idle && !queue_empty);
      if (idle && queue_empty) break;
      if (idle) begin
        c = pending.pop_front();
        model_exec(c, 1000);
        busy_until = t + len_eff(c) + 2;
      end
      if (t > 20000) begin
        check_eq("stream_timeout", 1, 0);
        break;
      end
      @(negedge i_clk);
      t++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [63:0] c;
    for (int unsigned i = 0; i < 1024; i++) poke(18'(i), '0);
    for (int unsigned i = TOPW; i < DEPTH; i++) poke(18'(i), '0);

    // Reset held with a command waiting: no pop may happen.
    queue_empty = 1'b0;
    queue_cmd   = mk(0, 4, 0, 8, 16);
    repeat (3) begin
      @(negedge i_clk); #1;
      check_eq("rst_no_pop", issuer_rd_queue, 0);
    end
    @(negedge i_clk);
    i_rstn = 1'b0;
    queue_empty = 1'b1;
    #1;
    check_eq("fin_after_rst", finished_task, 1);
    check_eq("idle_no_pop", issuer_rd_queue, 0);
    repeat (2) begin
      @(negedge i_clk); #1;
      check_eq("idle_empty_fin", finished_task, 1);
    end
    compare_window();

    // ADD
    for (int unsigned i = 0; i < 4; i++) begin
      poke(18'(i), 32'(i + 1));
      poke(18'(8 + i), 32'(10 * (i + 1)));
    end
    pending.push_back(mk(0, 4, 0, 8, 16));
    run_stream();
    check_eq("add16", peek(16), 11);
    check_eq("add17", peek(17), 22);
    check_eq("add18", peek(18), 33);
    check_eq("add19", peek(19), 44);

    // DOT with wrap
    poke(200, 32'hFFFF_FFFF);
    poke(300, 32'd2);
    pending.push_back(mk(2, 1, 200, 300, 100));
    run_stream();
    check_eq("dot_wrap", peek(100), 32'hFFFF_FFFE);
    compare_window();

    // Back-to-back COPY
    for (int unsigned i = 0; i < 6; i++) poke(18'(400 + i), 32'(32'hC0DE_0000 + i));
    dut_pops = 0;
    for (int unsigned k = 0; k < 3; k++) pending.push_back(mk(3, 2, 400 + 2 * k, 0, 420 + 2 * k));
    run_stream();
    check_eq("b2b_pops", dut_pops, 3);
    check_eq("b2b_last", peek(425), 32'hC0DE_0005);

    // Address wrap
    poke(18'h3FFFF, 32'hA5A5);
    poke(0, 32'h5A5A);
    pending.push_back(mk(3, 2, 32'h3FFFF, 0, 500));
    run_stream();
    check_eq("wrap0", peek(500), 32'hA5A5);
    check_eq("wrap1", peek(501), 32'h5A5A);

    // Overlapping shift-by-one copy
    for (int unsigned i = 0; i < 7; i++) poke(18'(40 + i), 32'(100 + i));
    pending.push_back(mk(3, 6, 40, 0, 41));
    run_stream();
    check_eq("overlap_hi", peek(46), 105);
    check_eq("overlap_lo", peek(41), 100);
    compare_window();

    // Mid-command reset on a 256-element ADD
    for (int unsigned i = 0; i < 256; i++) begin
      poke(18'(i), $urandom);
      poke(18'(256 + i), $urandom);
      poke(18'(600 + i), 32'(32'hDEAD_0000 + i));
    end
    c = mk(0, 0, 0, 256, 600);
    @(negedge i_clk);
    queue_cmd = c;
    queue_empty = 1'b0;
    #1;
    check_eq("mr_pop", issuer_rd_queue, 1);
    @(negedge i_clk);
    queue_empty = 1'b1;
    for (int k = 1; k < 50; k++) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    check_eq("mr_no_pop", issuer_rd_queue, 0);
    check_eq("mr_idle", finished_task, 1);
    model_exec(c, 48);
    repeat (5) @(negedge i_clk);
    check_eq("mr_last_written", peek(647), ref_mem[647]);
    check_eq("mr_first_kept", peek(648), 32'hDEAD_0030);
    compare_window();

    // Randomized streams
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned i = 0; i < 1024; i++) poke(18'(i), $urandom);
      for (int unsigned k = 0; k < 15; k++)
        pending.push_back(mk($urandom_range(0, 3),
                             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24),
                             $urandom_range(0, 767), $urandom_range(0, 767),
                             $urandom_range(0, 767)));
      run_stream();
      compare_window();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/simd_top.md
SIMD_TOP -- requirements
Module: simd_top

Interface
REQ-001 SHALL have parameter DATA_W, default 32: shared-memory word width.
REQ-002 SHALL have parameter ADDR_W, default 18: word address width; MEM_DEPTH = 2**ADDR_W (262144).
REQ-003 SHALL use cmd_t, a 64-bit packed struct, MSB first:
- opcode[63:62]
- len[61:54]
- addr_a[53:36]
- addr_b[35:18]
- addr_d[17:0]
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rstn, input, 1: synchronous, active-high reset (1 = reset, sampled on the i_clk rising edge).
REQ-006 SHALL have port queue_cmd, input, 64 (cmd_t): head of the external command FIFO, valid whenever queue_empty=0.
REQ-007 SHALL have port queue_empty, input, 1: external FIFO holds no command.
REQ-008 SHALL have port issuer_rd_queue, output, 1: one-cycle pop strobe to the external FIFO.
REQ-009 SHALL have port finished_task, output, 1: all accepted work is complete and the queue is empty.
REQ-010 SHALL contain instances u_shared_mem (with storage array u_shared_mem.u_mem.r_mem[MEM_DEPTH], DATA_W bits each) and u_pool (execution engine), so benches can preload and dump memory by hierarchy.

Function
REQ-011 SHALL implement an issuer FSM with states IDLE, EXEC, WB:
- IDLE -> EXEC when queue_empty=0: assert issuer_rd_queue for exactly that cycle, latch queue_cmd, set element index i=0.
- EXEC -> WB after the read for element len_eff-1 is issued.
- WB -> IDLE after the final write.
REQ-012 SHALL issue at most one command at a time; a new command is never popped before the previous one returns to IDLE (in-order, dependency-safe stall).
REQ-013 SHALL compute len_eff = len, or 256 when len = 0.
REQ-014 SHALL read a[i]=mem[addr_a+i] and b[i]=mem[addr_b+i] for i = 0..len_eff-1 in ascending order, one element per cycle. Memory read latency SHALL be 1 cycle: data is available the cycle after the address.
REQ-015 SHALL execute opcodes as follows:
- 0 ADD: mem[addr_d+i] = a[i]+b[i]
- 1 SUB: mem[addr_d+i] = a[i]-b[i]
- 2 DOT: mem[addr_d] = sum over i of a[i]*b[i]; a single write in WB
- 3 COPY: mem[addr_d+i] = a[i]
REQ-016 SHALL truncate all arithmetic to DATA_W bits (wrap modulo 2**DATA_W); the DOT accumulator keeps the low DATA_W bits of each product and sum.
REQ-017 SHALL wrap all addresses modulo MEM_DEPTH.
REQ-018 SHALL perform the element-wise write of element i one cycle after its read. For overlapping ranges, results SHALL equal sequential ascending-order semantics with a 1-element read-ahead.
REQ-019 SHALL meet this command timing, with pop on cycle 0:
- reads on cycles 1..len_eff
- last write on cycle len_eff+1
- back in IDLE on cycle len_eff+2, when the next pop may occur
REQ-020 SHALL drive finished_task combinationally: 1 iff the FSM is in IDLE and queue_empty=1. It SHALL drop in the same cycle queue_empty falls.
REQ-021 SHALL NOT modify memory while in IDLE; memory is written only by the engine.
REQ-022 SHALL ignore queue_cmd whenever issuer_rd_queue=0.

Reset
REQ-023 While i_rstn=1 at a clock edge, SHALL force: FSM to IDLE, issuer_rd_queue=0, index and accumulator to 0, no memory write that cycle.
REQ-024 SHALL NOT clear memory contents on reset; backdoor-preloaded contents survive reset.
REQ-025 Reset asserted mid-command SHALL abort the command. Elements already written stay written; the popped command is not replayed.
REQ-026 After reset release with queue_empty=1, finished_task SHALL read 1 in the first cycle.

Verification
REQ-027 ADD: preload mem[0..3]=1,2,3,4 and mem[8..11]=10,20,30,40; queue {ADD, len=4, a=0, b=8, d=16} -> mem[16..19]=11,22,33,44; finished_task returns to 1 on cycle 6 after the pop.
REQ-028 DOT wrap: preload a=0xFFFFFFFF, b=2, len=1; queue {DOT, d=100} -> mem[100]=0xFFFFFFFE; no other address written.
REQ-029 Back-to-back: queue 3 COPY commands, len=2 each -> issuer_rd_queue pulses exactly 3 times, spaced 4 cycles apart; finished_task stays 0 until the last command completes.
REQ-030 Empty and refill: queue_empty=1 -> finished_task=1 with no pop. Then drive queue_empty=0 -> finished_task=0 in the same cycle and a pop on the next edge.
REQ-031 Mid-command reset: len=0 (256-element) ADD, assert i_rstn at cycle 50 -> issuer_rd_queue=0 and FSM in IDLE the next cycle; writes stop; preloaded memory is intact.
REQ-032 Address wrap: addr_a=0x3FFFF, len=2, COPY -> reads mem[0x3FFFF] then mem[0].
